// File: rtl/cdc_pkg.sv
// Shared types and constants for the req/ack bundled-data CDC blocks.
package cdc_pkg;

  // Fewest flops that still give a metastability-settling stage.
  localparam int SYNC_STAGES_MIN = 2;

  // Transmit-side handshake states; encoding 2'b11 is unused.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    REQ_HIGH     = 2'b01,
    WAIT_ACK_LOW = 2'b10
  } tx_state_e;

endpackage

// File: rtl/cdc_handshake_tx_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// STAGES flops in series; q is the last stage.
module cdc_handshake_tx_sync
  import cdc_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  // NOTE: every synchronizer flop is reset so a stale ack cannot leak out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Transmit end of a 4-phase req/ack bundled-data clock-domain crossing.
// Captures a word on valid/ready, holds it on data_out while req_out is
// high, and completes the handshake from a synchronized copy of ack_in.
// Optional feature: define CDC_HANDSHAKE_TX_TIMEOUT_EN to build a sticky
// timeout_err flag for handshakes that stall in either wait state.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             done,
  output logic             timeout_err
);

  // A chain shorter than the minimum would not settle metastability.
  localparam int STAGES_EFF = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic             ack_sync;
  tx_state_e        state_q;
  tx_state_e        state_d;
  logic             req_d;
  logic [WIDTH-1:0] data_d;
  logic             done_d;

  cdc_handshake_tx_sync #(
    .STAGES (STAGES_EFF)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (ack_sync)
  );

  // A held-high ack (stale or receiver not yet released) blocks new requests.
  assign in_ready = (state_q == IDLE) && !ack_sync;

  // Next-state, request, data and completion-pulse decode.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    req_d   = req_out;
    data_d  = data_out;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = REQ_HIGH;
        end
      end
      REQ_HIGH: begin
        req_d = 1'b1;
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        req_d = 1'b0;
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        // Unused encoding recovers to a quiet IDLE.
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Register the state and all outputs so req_out is glitch-free.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_out  <= req_d;
      data_out <= data_d;
      done     <= done_d;
    end
  end

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // Count cycles spent in a wait state; flag sticks until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wait_cnt_q <= '0;
      end else if (((state_q == REQ_HIGH) || (state_q == WAIT_ACK_LOW)) && (wait_cnt_q != CNT_MAX)) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (wait_cnt_q == CNT_MAX) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx (WIDTH=8, SYNC_STAGES=2,
// TIMEOUT_CYCLES=16). Stimulus pushes expected words into a queue; a
// monitor pops and compares them on every rising req_out.
module tb_cdc_handshake_tx;

  localparam int WIDTH = 8;

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             req_out;
  logic             ack_in;
  logic             done;
  logic             timeout_err;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int exp_req  = 0;
  int exp_done = 0;
  int req_cnt  = 0;
  int done_cnt = 0;
  logic rx_en  = 1'b0;

  cdc_handshake_tx #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push an expected word and account for its request pulse.
  task automatic expect_word(input logic [WIDTH-1:0] w);
    exp_q.push_back(w);
    exp_req++;
  endtask

  // Receiver side: raise ack, wait for req to fall, drop ack, wait for done.
  task automatic respond_ack();
    int n;
    ack_in = 1'b1;
    n = 0;
    while (req_out && n < 12) begin step(); n++; end
    check("ack_req_fall_timeout", {31'd0, req_out}, 32'd0);
    ack_in = 1'b0;
    n = 0;
    while (!done && n < 12) begin step(); n++; end
    check("ack_done_timeout", {31'd0, done}, 32'd1);
    exp_done++;
    step();
  endtask

  // Monitor: compare data on each rising req_out, count done pulses.
  initial begin
    logic prev_req  = 1'b0;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (req_out && !prev_req) begin
        req_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          check("req_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        check("done_one_cycle", {31'd0, prev_done}, 32'd0);
      end
      prev_req  = req_out;
      prev_done = done;
    end
  end

  // Auto-responding receiver: ack follows req one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rx_en) ack_in = req_out;
    end
  end

  // Hard stop if something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] words [3];
    int n;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; ack_in = 1'b0;

    // 1. Reset
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_req",      {31'd0, req_out},  32'd0);
    check("rst_data",     {24'd0, data_out}, 32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_timeout",  {31'd0, timeout_err}, 32'd0);

    // 2. Single transfer with exact latencies, 3. busy hold
    in_valid = 1'b1; in_data = 8'hA5;
    expect_word(8'hA5);
    step();
    check("acc_data", {24'd0, data_out}, 32'hA5);
    check("acc_req",  {31'd0, req_out},  32'd1);
    in_data = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      step();
      check("busy_data",  {24'd0, data_out}, 32'hA5);
      check("busy_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    ack_in = 1'b1;
    step(); check("req_hold_e1", {31'd0, req_out}, 32'd1);
    step(); check("req_hold_e2", {31'd0, req_out}, 32'd1);
    step(); check("req_fall_e3", {31'd0, req_out}, 32'd0);
    check("wait_ready", {31'd0, in_ready}, 32'd0);
    step();
    ack_in = 1'b0;
    step(); check("done_e1", {31'd0, done}, 32'd0);
    step(); check("done_e2", {31'd0, done}, 32'd0);
    check("done_e2_ready", {31'd0, in_ready}, 32'd0);
    step(); check("done_e3", {31'd0, done}, 32'd1);
    check("done_ready", {31'd0, in_ready}, 32'd1);
    exp_done++;
    step(); check("done_clear", {31'd0, done}, 32'd0);
    check("idle_ready", {31'd0, in_ready}, 32'd1);

    // 4. Back-to-back with auto-responding receiver
    rx_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i];
      n = 0;
      while (!in_ready && n < 40) begin step(); n++; end
      check("b2b_ready_timeout", {31'd0, in_ready}, 32'd1);
      expect_word(words[i]);
      exp_done++;
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (done_cnt < exp_done && n < 60) begin step(); n++; end
    check("b2b_done_count", done_cnt, exp_done);
    rx_en = 1'b0;
    ack_in = 1'b0;
    repeat (4) step();

    // 5. Reset mid-handshake
    in_valid = 1'b1; in_data = 8'h5A;
    expect_word(8'h5A);
    step();
    in_valid = 1'b0;
    ack_in = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_req",  {31'd0, req_out},  32'd0);
    check("mid_rst_data", {24'd0, data_out}, 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stale_ack_ready", {31'd0, in_ready}, 32'd0);
      check("stale_ack_req",   {31'd0, req_out},  32'd0);
    end
    ack_in = 1'b0;
    expect_word(8'h77);
    step(); check("release_e1_ready", {31'd0, in_ready}, 32'd0);
    step(); check("release_e2_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("w77_req",  {31'd0, req_out},  32'd1);
    check("w77_data", {24'd0, data_out}, 32'h77);
    respond_ack();

    // 6. Timeout (flag only when the feature is built)
    in_valid = 1'b1; in_data = 8'hC3;
    expect_word(8'hC3);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("to_early", {31'd0, timeout_err}, 32'd0);
    repeat (10) step();
    check("to_set", {31'd0, timeout_err}, {31'd0, TO_EXP});
    check("to_req_held", {31'd0, req_out}, 32'd1);
    respond_ack();
    check("to_sticky", {31'd0, timeout_err}, {31'd0, TO_EXP});
    rst_n = 1'b0;
    #1;
    check("to_rst_clear", {31'd0, timeout_err}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Scoreboard totals
    check("req_count",  req_cnt,  exp_req);
    check("done_count", done_cnt, exp_done);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-domain (transmit) end of a 4-phase req/ack bundled-data clock-domain crossing. It captures a word from a local valid/ready interface, holds it stable on data_out, and raises req_out. It then waits for the receiver's asynchronous ack_in, brought in through an internal multi-flop synchronizer, to complete the handshake. It pairs with the receive-side block, which synchronizes req_out with the team's synchronizer.

Parameters:
- WIDTH, 8, bit width of the transferred word.
- SYNC_STAGES, 2, number of flops in the ack_in synchronizer chain (minimum 2).
- TIMEOUT_CYCLES, 1024, cycles allowed in either wait state before timeout_err is set. Used only with the optional feature.

Ports:
- clk  input  1  single clock; all state is on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- data_out  output  WIDTH  held word; stable whenever req_out=1.
- req_out  output  1  request to the destination domain; registered, glitch-free.
- ack_in  input  1  acknowledge from the destination domain; asynchronous to clk.
- done  output  1  one-cycle pulse when a handshake completes.
- timeout_err  output  1  sticky timeout flag; tied to 0 when the feature is compiled out.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, req_out=0, data_out=0, done=0, timeout_err=0, all synchronizer flops=0.
- ack_sync is the output of a SYNC_STAGES-deep flop chain on ack_in. The FSM uses only ack_sync, never raw ack_in.
- in_ready is combinational: (state==IDLE) && (ack_sync==0).
- States and transitions:
  - IDLE: on the edge where in_valid && in_ready: data_out<=in_data, req_out<=1, go to REQ_HIGH.
  - REQ_HIGH: on an edge with ack_sync==1: req_out<=0, go to WAIT_ACK_LOW.
  - WAIT_ACK_LOW: on an edge with ack_sync==0: done<=1 for exactly one cycle, go to IDLE.
- Latency:
  - req_out rises on the accepting edge.
  - req_out falls on the (SYNC_STAGES+1)th rising edge after ack_in rises.
  - done pulses on the (SYNC_STAGES+1)th rising edge after ack_in falls.
- data_out changes only on an accepting edge. in_data and in_valid are ignored outside IDLE.
- Back-to-back transfers: the next word may be accepted in the cycle done is high, because in_ready is already 1.
- ack_in high while in IDLE (stale ack or receiver not yet released): in_ready=0 and no request is issued until ack_sync returns to 0.
- Reset mid-handshake: req_out drops immediately and the FSM returns to IDLE. The protocol restarts only after ack_sync is 0.
- A glitchy ack_in shorter than one clock may or may not be seen. The FSM tolerates either outcome without an illegal state.
- The state encoding is 2 bits. The unused encoding returns to IDLE with req_out=0.

Optional Feature:
- Macro: CDC_HANDSHAKE_TX_TIMEOUT_EN.
- With the macro: a cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on every state change. It increments while the FSM is in REQ_HIGH or WAIT_ACK_LOW. When it reaches TIMEOUT_CYCLES, timeout_err<=1 and stays set until reset. The handshake is not aborted.
- Without the macro: no counter logic is built and timeout_err is constant 0.

Decomposition:
- Package cdc_pkg holds:
  - the state enum typedef (IDLE, REQ_HIGH, WAIT_ACK_LOW);
  - the localparam for the minimum SYNC_STAGES (2).
- One sub-module: the existing synchronizer (WIDTH=1), instantiated for ack_in. Its stage count is parameterized, or it is chained to SYNC_STAGES.
- Everything else is a single always_ff FSM plus the in_ready and done logic.

Test Plan (WIDTH=8, SYNC_STAGES=2, TIMEOUT_CYCLES=16 for test 6):
1. Reset with ack_in=0: hold rst_n=0 for 3 cycles, then release -> req_out=0, data_out=0x00, done=0, in_ready=1.
2. Single transfer: in_valid=1, in_data=0xA5 for one edge -> data_out=0xA5 and req_out=1 after that edge. Then:
   - the bench raises ack_in 2 cycles later -> req_out=0 on the 3rd edge;
   - the bench drops ack_in -> done=1 for exactly one cycle on the 3rd edge, then in_ready=1.
3. Busy hold: while in REQ_HIGH, drive in_data=0x3C with in_valid=1 -> data_out stays 0xA5 and in_ready=0 throughout.
4. Back-to-back: stream 0x01, 0x02, 0x03 with in_valid held high and an auto-responding receiver model -> exactly three req_out pulses carrying 0x01, 0x02, 0x03 in order and three done pulses.
5. Reset mid-handshake: assert rst_n=0 in REQ_HIGH while ack_in=1 -> req_out=0 immediately and in_ready=0 until 2 edges after ack_in falls. The next word 0x77 then completes normally.
6. Timeout (macro defined): never raise ack_in after a request -> timeout_err=1 after 16 cycles in REQ_HIGH, stays 1 after a late ack completes the handshake, and clears only on reset. With the macro undefined, timeout_err stays 0.
